// File: rtl/snitch_ssr_isect_nway.sv
// N-way sorted-index intersector/merger.
// Consumes NumIn ascending index streams. In intersection mode it emits the
// indices common to all streams. In merge mode it emits every distinct index
// with a mask of the streams that hold it. One done beat per job reports the
// emitted count.
module snitch_ssr_isect_nway #(
    parameter int unsigned NumIn      = 3,
    parameter int unsigned IndexWidth = 14,
    parameter int unsigned CountWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic                        cfg_merge_i,
    input  logic [NumIn-1:0]            cfg_empty_i,
    input  logic [NumIn-1:0]            idx_valid_i,
    output logic [NumIn-1:0]            idx_ready_o,
    input  logic [NumIn*IndexWidth-1:0] idx_data_i,
    input  logic [NumIn-1:0]            idx_last_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [IndexWidth-1:0]       out_idx_o,
    output logic [NumIn-1:0]            out_mask_o,
    output logic                        done_valid_o,
    input  logic                        done_ready_i,
    output logic [CountWidth-1:0]       done_count_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state, state_next;
    logic                  merge;
    logic [NumIn-1:0]      exh, active, eq_mask, pop;
    logic [CountWidth-1:0] count;
    logic                  out_valid;
    logic [IndexWidth-1:0] out_idx;
    logic [NumIn-1:0]      out_mask;
    logic [IndexWidth-1:0] min_idx;
    logic                  heads_valid, out_free, fire, cfg_hs;

    assign active      = ~exh;
    assign heads_valid = (&(idx_valid_i | exh)) && (|active);
    assign out_free    = !out_valid || out_ready_i;
    assign cfg_hs      = (state == StIdle) && cfg_valid_i;

    // Smallest head over the active streams, and which active heads equal it
    always_comb begin
        min_idx = '1;
        eq_mask = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (active[i] && (idx_data_i[i*IndexWidth +: IndexWidth] < min_idx)) begin
                min_idx = idx_data_i[i*IndexWidth +: IndexWidth];
            end
        end
        for (int unsigned i = 0; i < NumIn; i++) begin
            eq_mask[i] = active[i] && (idx_data_i[i*IndexWidth +: IndexWidth] == min_idx);
        end
    end

    // Step decision: which streams pop, whether an index is emitted, next state
    always_comb begin
        pop        = '0;
        fire       = 1'b0;
        state_next = state;
        case (state)
            StIdle: begin
                if (cfg_valid_i) begin
                    if (&cfg_empty_i)                     state_next = StDone;
                    else if (!cfg_merge_i && |cfg_empty_i) state_next = StFlush;
                    else                                  state_next = StRun;
                end
            end
            StRun: begin
                if (!merge && |exh) begin
                    state_next = StFlush;
                end else if (merge && &exh) begin
                    if (!out_valid) state_next = StDone;
                end else if (heads_valid) begin
                    if (merge || (eq_mask == active)) begin
                        if (out_free) begin
                            fire = 1'b1;
                            pop  = merge ? eq_mask : active;
                        end
                    end else begin
                        // Intersection skip never touches the out register
                        pop = eq_mask;
                    end
                end
            end
            StFlush: begin
                pop = active & idx_valid_i;
                if ((&exh) && !out_valid) state_next = StDone;
            end
            StDone: begin
                if (done_ready_i) state_next = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    // Job state: FSM, mode, exhausted mask and saturating emit counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= StIdle;
            merge <= 1'b0;
            exh   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (cfg_hs) begin
                merge <= cfg_merge_i;
                exh   <= cfg_empty_i;
                count <= '0;
            end else begin
                exh <= exh | (pop & idx_last_i);
                if (fire && (count != '1)) count <= count + 1'b1;
            end
        end
    end

    // Output register: loaded on an emitting step, cleared when accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_mask  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_idx   <= min_idx;
            out_mask  <= eq_mask;
        end else if (out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    assign cfg_ready_o  = (state == StIdle);
    assign idx_ready_o  = pop;
    assign out_valid_o  = out_valid;
    assign out_idx_o    = out_idx;
    assign out_mask_o   = out_mask;
    assign done_valid_o = (state == StDone);
    assign done_count_o = count;

endmodule

// File: tb/tb_snitch_ssr_isect_nway.sv
// Directed bench for snitch_ssr_isect_nway with a set-based reference model.
module tb_snitch_ssr_isect_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_merge;
    logic [2:0]  cfg_empty;
    logic [2:0]  idx_valid, idx_ready, idx_last;
    logic [41:0] idx_data;
    logic        out_valid, out_ready;
    logic [13:0] out_idx;
    logic [2:0]  out_mask;
    logic        done_valid, done_ready;
    logic [15:0] done_count;

    int checks = 0;
    int failures = 0;

    int sdata[3][64];
    int slen[3];
    int ptr[3];
    int exp_idx[$];
    int exp_msk[$];

    always #5 clk = ~clk;

    snitch_ssr_isect_nway #(.NumIn(3), .IndexWidth(14), .CountWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_merge_i(cfg_merge), .cfg_empty_i(cfg_empty),
        .idx_valid_i(idx_valid), .idx_ready_o(idx_ready),
        .idx_data_i(idx_data), .idx_last_i(idx_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_idx_o(out_idx), .out_mask_o(out_mask),
        .done_valid_o(done_valid), .done_ready_i(done_ready),
        .done_count_o(done_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ld(input int s, input int n, input int a0, input int a1,
                      input int a2, input int a3);
        slen[s] = n;
        sdata[s][0] = a0; sdata[s][1] = a1; sdata[s][2] = a2; sdata[s][3] = a3;
    endtask

    // Reference: walk the index space, classify each value by set membership
    task automatic build_model(input bit mrg);
        exp_idx.delete();
        exp_msk.delete();
        for (int v = 0; v < 128; v++) begin
            int m;
            m = 0;
            for (int s = 0; s < 3; s++)
                for (int k = 0; k < slen[s]; k++)
                    if (sdata[s][k] == v) m = m | (1 << s);
            if (mrg ? (m != 0) : (m == 7)) begin
                exp_idx.push_back(v);
                exp_msk.push_back(m);
            end
        end
    endtask

    task automatic drive_streams(input int cyc, input bit gap);
        for (int s = 0; s < 3; s++) begin
            bit have;
            have = ptr[s] < slen[s];
            idx_valid[s] = have && !(gap && s == 1 && (cyc % 3) == 0);
            idx_data[s*14 +: 14] = have ? 14'(sdata[s][ptr[s]]) : 14'd0;
            idx_last[s] = have && (ptr[s] == slen[s] - 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_mask"}, out_mask, 0);
        chk({tag, "_idx_ready"}, idx_ready, 0);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_done_count"}, done_count, 0);
    endtask

    // Runs one job from a negedge; returns cycles to done, emit count, emit span
    task automatic run_job(input bit mrg, input logic [2:0] emp, input bit toggle,
                           input bit gap, input int abort_after, input int exp_cnt,
                           output int done_cyc, output int nemit, output int span);
        int cyc, first, last, exp_n;
        bit finished, aborted, prev_stall;
        logic [13:0] prev_idx;
        logic [2:0]  prev_msk, pop;
        build_model(mrg);
        exp_n = exp_idx.size();
        for (int s = 0; s < 3; s++) ptr[s] = 0;
        cyc = 0; nemit = 0; first = -1; last = -1; span = -1; done_cyc = -1;
        finished = 0; aborted = 0; prev_stall = 0; pop = '0;
        prev_idx = '0; prev_msk = '0;
        drive_streams(0, gap);
        out_ready = 1'b1; done_ready = 1'b0;
        cfg_valid = 1'b1; cfg_merge = mrg; cfg_empty = emp;
        #1 chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        while (!finished && !aborted && cyc < 600) begin
            for (int s = 0; s < 3; s++) if (pop[s]) ptr[s]++;
            cyc++;
            drive_streams(cyc, gap);
            out_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, prev_idx);
                chk("stall_mask", out_mask, prev_msk);
            end
            chk("pop_without_valid", idx_ready & ~idx_valid, 0);
            if (mrg && out_valid && !out_ready) chk("pop_while_full", idx_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_idx.size() == 0) chk("extra_emit", out_idx, -1);
                else begin
                    chk("emit_idx", out_idx, exp_idx.pop_front());
                    chk("emit_mask", out_mask, exp_msk.pop_front());
                end
                nemit++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx = out_idx;
            prev_msk = out_mask;
            pop = idx_ready & idx_valid;
            if (done_valid) begin
                finished = 1;
            end else if (abort_after > 0 && nemit == abort_after) begin
                aborted = 1;
                #1 rst_n = 1'b0;
                #1 check_reset_outputs("abort");
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (aborted) return;
        if (!finished) begin
            chk("job_timeout", cyc, -1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        done_cyc = cyc;
        span = last - first;
        chk("done_count_model", done_count, exp_n);
        if (exp_cnt >= 0) chk("done_count_literal", done_count, exp_cnt);
        chk("done_out_valid", out_valid, 0);
        chk("missing_emits", exp_idx.size(), 0);
        chk("nemit", nemit, exp_n);
        for (int s = 0; s < 3; s++) chk("stream_consumed", ptr[s], slen[s]);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        #1;
        chk("done_cleared", done_valid, 0);
        chk("cfg_ready_after", cfg_ready, 1);
        @(negedge clk);
    endtask

    task automatic load_basic();
        ld(0, 4, 1, 4, 7, 9);
        ld(1, 3, 4, 5, 9, 0);
        ld(2, 4, 0, 4, 9, 12);
    endtask

    initial begin
        int dc, ne, sp;
        int u_idx[7];
        int u_msk[7];
        u_idx = '{0, 1, 4, 5, 7, 9, 12};
        u_msk = '{4, 1, 7, 2, 1, 7, 4};
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_merge = 1'b0; cfg_empty = '0;
        idx_valid = '0; idx_data = '0; idx_last = '0;
        out_ready = 1'b0; done_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin slen[s] = 0; ptr[s] = 0; end
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model against hand-derived results
        load_basic();
        build_model(1'b0);
        chk("model_isect_n", exp_idx.size(), 2);
        chk("model_isect_0", exp_idx[0], 4);
        chk("model_isect_1", exp_idx[1], 9);
        build_model(1'b1);
        chk("model_union_n", exp_idx.size(), 7);
        for (int k = 0; k < 7; k++) begin
            chk("model_union_idx", exp_idx[k], u_idx[k]);
            chk("model_union_msk", exp_msk[k], u_msk[k]);
        end

        // Intersection, with gaps on stream B
        load_basic();
        run_job(1'b0, 3'b000, 1'b0, 1'b1, 0, 2, dc, ne, sp);
        // Union
        load_basic();
        run_job(1'b1, 3'b000, 1'b0, 1'b0, 0, 7, dc, ne, sp);
        // Union under alternating back-pressure
        load_basic();
        run_job(1'b1, 3'b000, 1'b1, 1'b0, 0, 7, dc, ne, sp);
        // Intersection under back-pressure
        load_basic();
        run_job(1'b0, 3'b000, 1'b1, 1'b0, 0, 2, dc, ne, sp);
        // Empty stream B in intersection
        load_basic();
        slen[1] = 0;
        run_job(1'b0, 3'b010, 1'b0, 1'b0, 0, 0, dc, ne, sp);
        chk("empty_done_latency_ok", (dc > 0 && dc <= 6), 1);
        // All empty, union
        slen[0] = 0; slen[1] = 0; slen[2] = 0;
        run_job(1'b1, 3'b111, 1'b0, 1'b0, 0, 0, dc, ne, sp);
        // Reset after two emits, then a fresh job
        load_basic();
        run_job(1'b1, 3'b000, 1'b0, 1'b0, 2, -1, dc, ne, sp);
        load_basic();
        run_job(1'b0, 3'b000, 1'b0, 1'b0, 0, 2, dc, ne, sp);
        // Throughput: identical 0..63 streams
        for (int s = 0; s < 3; s++) begin
            slen[s] = 64;
            for (int k = 0; k < 64; k++) sdata[s][k] = k;
        end
        run_job(1'b0, 3'b000, 1'b0, 1'b0, 0, 64, dc, ne, sp);
        chk("throughput_emits", ne, 64);
        chk("throughput_span", sp, 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snitch_ssr_isect_nway.md
Name: snitch_ssr_isect_nway

Overview:
N-way sorted-index comparator that generalises the two-master/one-slave SSR intersector. It takes NumIn ascending index streams from SSR index fetchers. In intersect mode it emits only indices present in every stream; in merge (union) mode it emits every distinct index, with a mask naming the contributing streams. The emitted index/mask stream drives the data fetchers and an isect slave SSR, and a done beat reports the emitted count per job.

Parameters:
NumIn, 3, number of input index streams (>=2)
IndexWidth, 14, width of each index
CountWidth, 16, width of emitted-element counter (saturating)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  job start request
cfg_ready_o  out  1  job accepted (high only in IDLE)
cfg_merge_i  in  1  1=union, 0=intersection
cfg_empty_i  in  NumIn  streams with zero length for this job
idx_valid_i  in  NumIn  per-stream head valid
idx_ready_o  out  NumIn  per-stream pop
idx_data_i  in  NumIn*IndexWidth  per-stream head index
idx_last_i  in  NumIn  head is final element of its stream
out_valid_o  out  1  emitted index valid
out_ready_i  in  1  downstream accept
out_idx_o  out  IndexWidth  emitted index
out_mask_o  out  NumIn  streams whose head equals out_idx_o
done_valid_o  out  1  job finished
done_ready_i  in  1  done accepted
done_count_o  out  CountWidth  number of indices emitted this job

Behaviour:
- Reset (async, rst_ni=0): state IDLE; every output 0 except cfg_ready_o=1; exhausted mask, count and out register cleared. Reset mid-job abandons the job; no done beat is produced.
- States: IDLE -> RUN on cfg handshake. RUN -> FLUSH (intersection only) when any stream exhausts while others remain. RUN/FLUSH -> DONE when the termination rule holds and the out register is empty. DONE -> IDLE on done handshake.
- On cfg handshake: latch merge mode, set exh=cfg_empty_i, count=0.
- Active set A = streams with exh=0. Step condition in RUN: all A heads valid and A nonempty.
- min = smallest idx_data over A; eq mask = A heads equal to min.
- Intersection:
  - If eq==A: emit, and pop all A.
  - Otherwise: pop eq streams only, with no emit (skip), regardless of out register state.
- Union: always emit min with mask eq, and pop eq streams.
- An emitting step fires only if the out register is free (!out_valid_o || out_ready_i). Otherwise no pops occur.
- Pop sets idx_ready_o only for the popped streams, in the same cycle as the step. A popped stream with idx_last_i=1 sets its exh bit.
- Out register: out_valid_o rises the cycle after the emitting step (1-cycle latency). It holds stable until out_ready_i. Full throughput is one emit per cycle.
- count increments on each emitting step and saturates at 2^CountWidth-1.
- Termination:
  - Intersection: any exh bit set. If other streams are still active, enter FLUSH. FLUSH pops every valid active head each cycle, with no emit, until all are exhausted.
  - Union: all exh bits set.
- DONE: done_valid_o=1 and done_count_o=count, held until done_ready_i. out_valid_o is already 0.
- cfg_empty_i all ones, or any bit in intersection mode: go straight to FLUSH/DONE with count 0.
- Inputs are assumed ascending and duplicate-free per stream. Unsorted input gives unspecified output but must not hang.

Test Plan:
- Intersect, NumIn=3: A={1,4,7,9}, B={4,5,9}, C={0,4,9,12} -> emits 4,9 with mask 3'b111, done_count=2. All streams fully popped, including C's 12 during FLUSH.
- Union, same streams -> emits 0,1,4,5,7,9,12 with masks 100,001,111,010,001,111,100, done_count=7.
- Back-pressure: union with out_ready_i toggling 1010… -> every beat is held stable while stalled, no index is lost or duplicated, and no pops occur while the out register is full.
- Empty: cfg_empty_i=3'b010 in intersection -> no emits; A and C flushed; done_count=0 within stream-length+2 cycles.
- Reset mid-job: assert rst_ni=0 after 2 emits -> all outputs 0 and cfg_ready_o=1 immediately. A new job then completes with a correct count.
- Throughput: identical streams {0..63} x3, intersection, out_ready_i=1 -> 64 emits on consecutive cycles, done_count=64.
